dbus_initiator: RTL and testbench

- Data-bus initiator: the requesting end of the peripheral data bus that GPIO and the other memory-mapped peripherals respond on.
- Takes single register-access commands from a valid/ready command port.
- Decodes the target peripheral from address bits, drives the peripheral select and the type_dbus2peri_s request, and waits for the responder's ack.
- Returns read data and error status on a valid/ready response port; one outstanding transaction at a time.

---
 rtl/dbus_initiator.sv | 181 ++++++++++++++++++
 tb/tb_dbus_initiator.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_initiator.sv
// Data-bus initiator: takes one register command at a time, drives one peripheral request
// and returns its response. Define DBUS_INIT_TIMEOUT_EN to bound the wait for an ack.

typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        w_en;
    logic        req;
} type_dbus2peri_s;

typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
} type_peri2dbus_s;

module dbus_initiator #(
    parameter int unsigned NUM_PERI    = 4,
    parameter int unsigned IDX_LSB     = 8,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [31:0]         cmd_addr_i,
    input  logic                cmd_we_i,
    input  logic [31:0]         cmd_wdata_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_err_o,
    output logic [NUM_PERI-1:0] peri_sel_o,
    output type_dbus2peri_s     dbus2peri_o,
    input  type_peri2dbus_s     peri2dbus_i [NUM_PERI]
);

    if (NUM_PERI < 1 || NUM_PERI > 16 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("dbus_initiator: NUM_PERI must be 1..16 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [NUM_PERI-1:0] peri_sel_q, peri_sel_d;
    type_dbus2peri_s     bus_q, bus_d;

    logic [IDX_W-1:0]    cmd_idx;
    logic                idx_ok;
    logic [31:0]         cmd_offset;
    logic                sel_ack;
    logic [31:0]         sel_rdata;
    logic                timed_out;

    assign cmd_idx    = cmd_addr_i[IDX_LSB +: IDX_W];
    assign idx_ok     = 32'(cmd_idx) < NUM_PERI;
    assign cmd_offset = cmd_addr_i & ((32'd1 << IDX_LSB) - 32'd1);

    // Select is one-hot, so OR-reduction picks only the addressed responder.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_PERI; i++) begin
            if (peri_sel_q[i]) begin
                sel_ack   = sel_ack | peri2dbus_i[i].ack;
                sel_rdata = sel_rdata | peri2dbus_i[i].r_data;
            end
        end
    end

`ifdef DBUS_INIT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter holds the number of ack-less REQ cycles already completed.
    assign timed_out = (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StReq && !sel_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        peri_sel_d  = peri_sel_q;
        bus_d       = bus_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (idx_ok) begin
                        state_d = StReq;
                        for (int unsigned i = 0; i < NUM_PERI; i++) begin
                            peri_sel_d[i] = (cmd_idx == IDX_W'(i));
                        end
                        bus_d.addr   = cmd_offset;
                        bus_d.w_data = cmd_we_i ? cmd_wdata_i : 32'h0;
                        bus_d.w_en   = cmd_we_i;
                        bus_d.req    = 1'b1;
                    end else begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            StReq: begin
                if (sel_ack || timed_out) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~sel_ack;
                    rsp_rdata_d = (sel_ack && !bus_q.w_en) ? sel_rdata : 32'h0;
                    peri_sel_d  = '0;
                    bus_d       = '0;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            peri_sel_q  <= '0;
            bus_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            peri_sel_q  <= peri_sel_d;
            bus_q       <= bus_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign peri_sel_o  = peri_sel_q;
    assign dbus2peri_o = bus_q;

endmodule

// File: tb/tb_dbus_initiator.sv
// Bench for dbus_initiator: vector table plus a response scoreboard, with a behavioural
// responder that also drives spurious acks on every non-selected peripheral.

module tb_dbus_initiator;

    localparam int unsigned NUM_PERI    = 4;
    localparam int unsigned IDX_LSB     = 8;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned TIMEOUT_CYC = 16;

    typedef struct {
        logic [31:0]         addr;
        logic                we;
        logic [31:0]         wdata;
        int                  ackw;      // ack in this REQ cycle (1-based), 0 = never
        logic [31:0]         rdv;
        int                  bp;        // cycles of rsp_ready low
        logic [NUM_PERI-1:0] exp_sel;
        logic [31:0]         exp_addr;
        logic [31:0]         exp_rdata;
        logic                exp_err;
        int                  exp_reqc;
    } vec_t;

    logic                clk;
    logic                rst_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [31:0]         cmd_addr;
    logic                cmd_we;
    logic [31:0]         cmd_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;
    logic [NUM_PERI-1:0] peri_sel;
    type_dbus2peri_s     d2p;
    type_peri2dbus_s     p2d [NUM_PERI];

    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          ack_wait = 0;
    logic [31:0] rd_val = '0;
    vec_t        sb_q [$];
    vec_t        vecs [8];

    dbus_initiator #(
        .NUM_PERI    (NUM_PERI),
        .IDX_LSB     (IDX_LSB),
        .IDX_W       (IDX_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_we_i    (cmd_we),
        .cmd_wdata_i (cmd_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .peri_sel_o  (peri_sel),
        .dbus2peri_o (d2p),
        .peri2dbus_i (p2d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Responder: noise acks everywhere except the selected peripheral, which acks on cue.
    initial forever begin
        int req_cyc;
        req_cyc = 0;
        forever begin
            @(negedge clk);
            if (d2p.req) req_cyc++;
            else req_cyc = 0;
            for (int i = 0; i < NUM_PERI; i++) begin
                p2d[i].r_data = 32'hBAD0_0000 | 32'(i);
                p2d[i].ack    = 1'b1;
                if (peri_sel[i]) begin
                    p2d[i].ack    = (ack_wait != 0 && req_cyc == ack_wait);
                    p2d[i].r_data = p2d[i].ack ? rd_val : 32'hBAD1_BAD1;
                end
            end
        end
    end

    // Monitor: checks bus fields every cycle, scores each response handshake.
    initial begin
        int   req_seen;
        int   bus_bad;
        int   rise_cyc;
        logic prev_valid;
        vec_t e;
        req_seen = 0; bus_bad = 0; rise_cyc = 0; prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_seen = 0; bus_bad = 0; prev_valid = 1'b0;
            end else begin
                if (d2p.req) begin
                    req_seen++;
                    if (sb_q.size() == 0) bus_bad++;
                    else if (peri_sel !== sb_q[0].exp_sel || d2p.addr !== sb_q[0].exp_addr ||
                             d2p.w_en !== sb_q[0].we ||
                             d2p.w_data !== (sb_q[0].we ? sb_q[0].wdata : 32'h0)) bus_bad++;
                end else if (peri_sel !== '0 || d2p !== '0) begin
                    bus_bad++;
                end
                if (rsp_valid && !prev_valid) rise_cyc = cyc;
                prev_valid = rsp_valid;
                if (rsp_valid && rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("spurious_rsp", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.exp_rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(e.exp_err));
                        chk("req_cycles", req_seen, e.exp_reqc);
                        chk("bus_fields", bus_bad, 0);
                        chk("rsp_latency", rise_cyc - accept_cyc, e.exp_reqc + 1);
                    end
                    req_seen = 0; bus_bad = 0;
                end
            end
        end
    end

    task automatic accept_cmd(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                              output logic got);
        int tries;
        cmd_addr = addr; cmd_we = we; cmd_wdata = wdata; cmd_valid = 1'b1;
        got = 1'b0; tries = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; break; end
            tries++;
        end
        if (got) begin
            @(posedge clk); #1;
            accept_cyc = cyc - 1;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", 32'(got), 32'd1);
        chk("accept_wait", tries, 0);
    endtask

    task automatic run_txn(input vec_t v);
        logic        got;
        logic [31:0] hold_rdata;
        logic        hold_err;
        int          unstable;
        sb_q.push_back(v);
        ack_wait = v.ackw; rd_val = v.rdv; rsp_ready = (v.bp == 0);
        accept_cmd(v.addr, v.we, v.wdata, got);
        if (!got) begin sb_q.delete(); return; end
        if (v.bp > 0) begin
            got = 1'b0;
            for (int k = 0; k < 64; k++) begin
                @(negedge clk);
                if (rsp_valid) begin got = 1'b1; break; end
            end
            chk("rsp_valid_seen", 32'(got), 32'd1);
            hold_rdata = rsp_rdata; hold_err = rsp_err; unstable = 0;
            for (int k = 1; k < v.bp; k++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_rdata !== hold_rdata || rsp_err !== hold_err || cmd_ready)
                    unstable++;
            end
            chk("bp_stable", unstable, 0);
            @(posedge clk); #1;
            rsp_ready = 1'b1;
        end
        got = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0) begin got = 1'b1; break; end
        end
        chk("rsp_handshake", 32'(got), 32'd1);
        chk("ready_after_hs", 32'(cmd_ready), 32'd1);
        chk("valid_after_hs", 32'(rsp_valid), 32'd0);
        if (!got) sb_q.delete();
        rsp_ready = 1'b0;
    endtask

    task automatic stuck_then_reset(input int wait_cyc);
        vec_t v;
        logic got;
        int   stale;
        v = '{32'h0000_0208, 1'b0, 32'h0, 0, 32'h99, 0, 4'b0100, 32'h08, 32'h0, 1'b0, 0};
        sb_q.push_back(v);
        ack_wait = 0; rsp_ready = 1'b1;
        accept_cmd(v.addr, v.we, v.wdata, got);
        repeat (wait_cyc) @(negedge clk);
        chk("still_waiting_req", 32'(d2p.req), 32'd1);
        chk("still_waiting_rsp", 32'(rsp_valid), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(d2p.req), 32'd0);
        chk("rst_sel", 32'(peri_sel), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        sb_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        chk("no_stale_rsp", stale, 0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t t;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_we = 1'b0; cmd_wdata = '0;
        rsp_ready = 1'b0;

        //          addr          we    wdata         ackw rdv           bp sel      addr   rdata         err  reqc
        vecs[0] = '{32'h0000_0004, 1'b1, 32'h0000_00FF, 1, 32'h1234_5678, 0, 4'b0001, 32'h04, 32'h0,        1'b0, 1};
        vecs[1] = '{32'h0000_0100, 1'b0, 32'h0000_CAFE, 3, 32'h0000_0055, 0, 4'b0010, 32'h00, 32'h55,       1'b0, 3};
        vecs[2] = '{32'h0000_0700, 1'b0, 32'h0,         1, 32'h1111_1111, 0, 4'b0000, 32'h00, 32'h0,        1'b1, 0};
        vecs[3] = '{32'h0000_03FC, 1'b1, 32'hA5A5_5A5A, 2, 32'h2222_2222, 0, 4'b1000, 32'hFC, 32'h0,        1'b0, 2};
        vecs[4] = '{32'hFFFF_F2AB, 1'b0, 32'h0,         1, 32'hDEAD_BEEF, 5, 4'b0100, 32'hAB, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[5] = '{32'h0000_0F00, 1'b1, 32'h0000_0001, 1, 32'h3333_3333, 5, 4'b0000, 32'h00, 32'h0,        1'b1, 0};
        vecs[6] = '{32'h0000_1010, 1'b0, 32'h0,         4, 32'h0BAD_F00D, 2, 4'b0001, 32'h10, 32'h0BAD_F00D, 1'b0, 4};
        vecs[7] = '{32'h0000_0310, 1'b0, 32'h0,         1, 32'h8000_0001, 0, 4'b1000, 32'h10, 32'h8000_0001, 1'b0, 1};

        #12;
        chk("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_hold_bus", 32'(d2p.req | d2p.w_en), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_peri_sel", 32'(peri_sel), 32'd0);
        chk("reset_bus_addr", d2p.addr, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Response fields persist after the handshake until the next response.
        chk("rdata_held", rsp_rdata, 32'h8000_0001);

`ifdef DBUS_INIT_TIMEOUT_EN
        t = '{32'h0000_0200, 1'b0, 32'h0, 0,  32'h77, 0, 4'b0100, 32'h00, 32'h0,  1'b1, 16};
        run_txn(t);
        t = '{32'h0000_0200, 1'b0, 32'h0, 16, 32'h77, 0, 4'b0100, 32'h00, 32'h77, 1'b0, 16};
        run_txn(t);
        t = '{32'h0000_0104, 1'b1, 32'h5, 17, 32'h66, 3, 4'b0010, 32'h04, 32'h0,  1'b1, 16};
        run_txn(t);
        stuck_then_reset(3);
`else
        t = vecs[0];
        stuck_then_reset(100);
`endif
        @(posedge clk); #1;
        run_txn(vecs[1]);
        run_txn(vecs[2]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
